// File: rtl/pipe_stage_reg.sv
// Elastic datapath stage register: 1-cycle latency, outputs driven from the main register only.
// Backpressure: SKID=1 parks one extra entry so InReady is registered; SKID=0 passes OutReady through to InReady.
module pipe_stage_reg #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int SKID           = 1
) (
   input  logic                      Clock,
   input  logic                      Reset,
   input  logic                      Flush,
   input  logic                      InValid,
   output logic                      InReady,
   input  logic                      RegWriteIn,
   input  logic [REG_ADDR_WIDTH-1:0] WriteRegisterIn,
   input  logic [DATA_WIDTH-1:0]     DataIn,
   output logic                      OutValid,
   input  logic                      OutReady,
   output logic                      RegWriteOut,
   output logic [REG_ADDR_WIDTH-1:0] WriteRegisterOut,
   output logic [DATA_WIDTH-1:0]     DataOut
);

   typedef struct packed {
      logic                      regWrite;
      logic [REG_ADDR_WIDTH-1:0] writeRegister;
      logic [DATA_WIDTH-1:0]     data;
   } entry_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t state, stateNext;
   entry_t mainReg, mainNext;
   entry_t skidReg, skidNext;
   entry_t inEntry;
   logic   inFire, outFire;

   assign inEntry = '{regWrite: RegWriteIn, writeRegister: WriteRegisterIn, data: DataIn};

   assign OutValid = (state != EMPTY);
   assign InReady  = (SKID != 0) ? (state != FULL) : (!OutValid || OutReady);
   assign inFire   = InValid && InReady;
   assign outFire  = OutValid && OutReady;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state   <= EMPTY;
         mainReg <= '0;
         skidReg <= '0;
      end else begin
         state   <= stateNext;
         mainReg <= mainNext;
         skidReg <= skidNext;
      end
   end

   // Flush only clears occupancy; the data regs may go stale since RegWriteOut is gated by OutValid.
   always_comb begin
      stateNext = state;
      mainNext  = mainReg;
      skidNext  = skidReg;
      if (Flush) begin
         stateNext = EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (inFire) begin
                  stateNext = ONE;
                  mainNext  = inEntry;
               end
            end
            ONE: begin
               if (inFire && !outFire && (SKID != 0)) begin
                  stateNext = FULL;
                  skidNext  = inEntry;
               end else if (inFire) begin
                  mainNext  = inEntry;
               end else if (outFire) begin
                  stateNext = EMPTY;
               end
            end
            FULL: begin
               if (outFire) begin
                  stateNext = ONE;
                  mainNext  = skidReg;
               end
            end
            default: stateNext = EMPTY;
         endcase
      end
   end

   assign RegWriteOut      = OutValid && mainReg.regWrite;
   assign WriteRegisterOut = mainReg.writeRegister;
   assign DataOut          = mainReg.data;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: vector table plus scoreboard on a SKID=1 instance, hand sequences on SKID=0.
module tb_pipe_stage_reg;

   logic        Clock;
   logic        Reset;

   logic        aFlush, aInValid, aInReady, aRegWriteIn, aOutValid, aOutReady, aRegWriteOut;
   logic [4:0]  aWriteRegisterIn, aWriteRegisterOut;
   logic [31:0] aDataIn, aDataOut;

   logic        bFlush, bInValid, bInReady, bRegWriteIn, bOutValid, bOutReady, bRegWriteOut;
   logic [4:0]  bWriteRegisterIn, bWriteRegisterOut;
   logic [31:0] bDataIn, bDataOut;

   pipe_stage_reg #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .SKID(1)) dutA (
      .Clock(Clock), .Reset(Reset), .Flush(aFlush),
      .InValid(aInValid), .InReady(aInReady),
      .RegWriteIn(aRegWriteIn), .WriteRegisterIn(aWriteRegisterIn), .DataIn(aDataIn),
      .OutValid(aOutValid), .OutReady(aOutReady),
      .RegWriteOut(aRegWriteOut), .WriteRegisterOut(aWriteRegisterOut), .DataOut(aDataOut)
   );

   pipe_stage_reg #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .SKID(0)) dutB (
      .Clock(Clock), .Reset(Reset), .Flush(bFlush),
      .InValid(bInValid), .InReady(bInReady),
      .RegWriteIn(bRegWriteIn), .WriteRegisterIn(bWriteRegisterIn), .DataIn(bDataIn),
      .OutValid(bOutValid), .OutReady(bOutReady),
      .RegWriteOut(bRegWriteOut), .WriteRegisterOut(bWriteRegisterOut), .DataOut(bDataOut)
   );

   typedef struct {
      logic        inVld, rw, oRdy, fl;
      logic [4:0]  wr;
      logic [31:0] d;
      logic        eVld, eRdy, eRw;
      logic [4:0]  eWr;
      logic [31:0] eD;
   } vec_t;

   vec_t        tbl[$];
   logic [37:0] qA[$];
   logic [37:0] qB[$];
   int          nVec = 0;
   int          nMis = 0;

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nVec++;
      if (act !== exp) begin
         nMis++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic addRow(input logic inVld, input logic rw, input logic [4:0] wr, input logic [31:0] d,
                         input logic oRdy, input logic fl, input logic eVld, input logic eRdy,
                         input logic eRw, input logic [4:0] eWr, input logic [31:0] eD);
      vec_t v;
      v.inVld = inVld; v.rw = rw; v.wr = wr; v.d = d; v.oRdy = oRdy; v.fl = fl;
      v.eVld = eVld; v.eRdy = eRdy; v.eRw = eRw; v.eWr = eWr; v.eD = eD;
      tbl.push_back(v);
   endtask

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   // Scoreboard: entries queued on in_fire, popped on out_fire; a stalled head must hold.
   initial begin
      logic [37:0] prevA, prevB, e;
      bit          stallA, stallB;
      stallA = 0; stallB = 0; prevA = '0; prevB = '0;
      forever begin
         @(negedge Clock);
         if (Reset) begin
            qA.delete(); qB.delete(); stallA = 0; stallB = 0;
         end else begin
            if (stallA) check("stallA_hold", 64'({aOutValid, aRegWriteOut, aWriteRegisterOut, aDataOut}), 64'({1'b1, prevA}));
            if (aFlush) qA.delete();
            else begin
               if (aOutValid && aOutReady) begin
                  if (qA.size() == 0) check("scbA_spurious_out", 64'(aDataOut), 64'hFFFF_FFFF_FFFF_FFFF);
                  else begin
                     e = qA.pop_front();
                     check("scbA_entry", 64'({aRegWriteOut, aWriteRegisterOut, aDataOut}), 64'(e));
                  end
               end
               if (aInValid && aInReady) qA.push_back({aRegWriteIn, aWriteRegisterIn, aDataIn});
            end
            stallA = aOutValid && !aOutReady && !aFlush;
            prevA  = {aRegWriteOut, aWriteRegisterOut, aDataOut};

            if (stallB) check("stallB_hold", 64'({bOutValid, bRegWriteOut, bWriteRegisterOut, bDataOut}), 64'({1'b1, prevB}));
            if (bFlush) qB.delete();
            else begin
               if (bOutValid && bOutReady) begin
                  if (qB.size() == 0) check("scbB_spurious_out", 64'(bDataOut), 64'hFFFF_FFFF_FFFF_FFFF);
                  else begin
                     e = qB.pop_front();
                     check("scbB_entry", 64'({bRegWriteOut, bWriteRegisterOut, bDataOut}), 64'(e));
                  end
               end
               if (bInValid && bInReady) qB.push_back({bRegWriteIn, bWriteRegisterIn, bDataIn});
            end
            stallB = bOutValid && !bOutReady && !bFlush;
            prevB  = {bRegWriteOut, bWriteRegisterOut, bDataOut};
         end
      end
   end

   initial begin
      Reset = 1'b1;
      aFlush = 0; aInValid = 0; aRegWriteIn = 0; aWriteRegisterIn = 0; aDataIn = 0; aOutReady = 0;
      bFlush = 0; bInValid = 0; bRegWriteIn = 0; bWriteRegisterIn = 0; bDataIn = 0; bOutReady = 0;

      // Table: {inVld, rw, wr, data, oRdy, flush} -> {OutValid, InReady, RegWriteOut, WriteRegisterOut, DataOut}
      addRow(1, 1, 31, 'h11,   0, 0,  1, 1, 1, 31, 'h11);
      addRow(0, 1, 17, 'hDEAD, 1, 0,  0, 1, 0, 0,  0);
      addRow(1, 0, 3,  'hA,    0, 0,  1, 1, 0, 3,  'hA);
      addRow(1, 1, 4,  'hB,    0, 0,  1, 0, 0, 3,  'hA);
      addRow(1, 1, 5,  'hEE,   0, 0,  1, 0, 0, 3,  'hA);
      addRow(0, 1, 9,  'hDEAD, 1, 0,  1, 1, 1, 4,  'hB);
      addRow(0, 1, 9,  'hDEAD, 1, 0,  0, 1, 0, 0,  0);
      addRow(1, 1, 7,  'h71,   0, 0,  1, 1, 1, 7,  'h71);
      addRow(1, 1, 8,  'h81,   0, 0,  1, 0, 1, 7,  'h71);
      addRow(1, 1, 9,  'hC,    0, 1,  0, 1, 0, 0,  0);
      addRow(0, 1, 9,  'hC,    1, 0,  0, 1, 0, 0,  0);
      addRow(1, 1, 1,  'h21,   1, 0,  1, 1, 1, 1,  'h21);
      addRow(1, 1, 2,  'h22,   1, 1,  0, 1, 0, 0,  0);
      addRow(1, 0, 6,  'h33,   1, 0,  1, 1, 0, 6,  'h33);
      addRow(1, 1, 10, 'h34,   1, 0,  1, 1, 1, 10, 'h34);
      addRow(0, 1, 11, 'hDEAD, 0, 0,  1, 1, 1, 10, 'h34);
      addRow(0, 1, 11, 'hDEAD, 1, 0,  0, 1, 0, 0,  0);

      step();
      step();
      check("rst_a_outvalid", 64'(aOutValid), 64'(0));
      check("rst_a_regwrite", 64'(aRegWriteOut), 64'(0));
      check("rst_a_wreg", 64'(aWriteRegisterOut), 64'(0));
      check("rst_a_data", 64'(aDataOut), 64'(0));
      check("rst_a_inready", 64'(aInReady), 64'(1));
      check("rst_b_outvalid", 64'(bOutValid), 64'(0));
      check("rst_b_inready", 64'(bInReady), 64'(1));
      Reset = 1'b0;

      foreach (tbl[i]) begin
         aInValid = tbl[i].inVld; aRegWriteIn = tbl[i].rw; aWriteRegisterIn = tbl[i].wr;
         aDataIn = tbl[i].d; aOutReady = tbl[i].oRdy; aFlush = tbl[i].fl;
         step();
         check($sformatf("row%0d_outvalid", i), 64'(aOutValid), 64'(tbl[i].eVld));
         check($sformatf("row%0d_inready", i), 64'(aInReady), 64'(tbl[i].eRdy));
         check($sformatf("row%0d_regwrite", i), 64'(aRegWriteOut), 64'(tbl[i].eRw));
         if (tbl[i].eVld) begin
            check($sformatf("row%0d_wreg", i), 64'(aWriteRegisterOut), 64'(tbl[i].eWr));
            check($sformatf("row%0d_data", i), 64'(aDataOut), 64'(tbl[i].eD));
         end
      end
      aFlush = 0;

      // Streaming with no bubbles
      aOutReady = 1; aInValid = 1; aRegWriteIn = 1; aWriteRegisterIn = 5'd12;
      for (int i = 1; i <= 8; i++) begin
         aDataIn = 32'(i);
         step();
         check($sformatf("stream%0d_data", i), 64'(aDataOut), 64'(i));
         check($sformatf("stream%0d_valid", i), 64'(aOutValid), 64'(1));
         check($sformatf("stream%0d_inready", i), 64'(aInReady), 64'(1));
      end
      aInValid = 0;
      step();
      check("stream_drain_valid", 64'(aOutValid), 64'(0));
      check("stream_drain_regwrite", 64'(aRegWriteOut), 64'(0));

      // SKID=0: combinational InReady and 1/cycle pass-through
      bInValid = 1; bRegWriteIn = 1; bWriteRegisterIn = 5'd2; bDataIn = 'h50; bOutReady = 0;
      #1;
      check("b_empty_inready", 64'(bInReady), 64'(1));
      step();
      check("b_first_valid", 64'(bOutValid), 64'(1));
      check("b_first_data", 64'(bDataOut), 64'h50);
      check("b_stall_inready", 64'(bInReady), 64'(0));
      bDataIn = 'h51;
      step();
      check("b_stall_data", 64'(bDataOut), 64'h50);
      bOutReady = 1;
      #1;
      check("b_release_inready", 64'(bInReady), 64'(1));
      for (int i = 1; i <= 6; i++) begin
         step();
         check($sformatf("b_pass%0d_data", i), 64'(bDataOut), 64'('h50 + i));
         check($sformatf("b_pass%0d_valid", i), 64'(bOutValid), 64'(1));
         bDataIn = 32'('h51 + i);
      end
      bInValid = 0;
      step();
      check("b_drain_valid", 64'(bOutValid), 64'(0));
      check("b_drain_regwrite", 64'(bRegWriteOut), 64'(0));

      // Async reset while FULL
      aOutReady = 0; aInValid = 1; aRegWriteIn = 1; aWriteRegisterIn = 5'd9; aDataIn = 'h91;
      step();
      aDataIn = 'h92;
      step();
      check("pre_reset_full", 64'(aInReady), 64'(0));
      #2;
      Reset = 1'b1;
      #1;
      check("async_rst_outvalid", 64'(aOutValid), 64'(0));
      check("async_rst_regwrite", 64'(aRegWriteOut), 64'(0));
      check("async_rst_data", 64'(aDataOut), 64'(0));
      check("async_rst_inready", 64'(aInReady), 64'(1));
      step();
      Reset = 1'b0; aInValid = 0;
      step();
      check("post_rst_outvalid", 64'(aOutValid), 64'(0));

      check("scbA_leftover", 64'(qA.size()), 64'(0));
      check("scbB_leftover", 64'(qB.size()), 64'(0));
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end

endmodule
